// File: rtl/wptr_binary_to_grey_if.sv
// wptr_binary_to_grey_if
// Bundles the producer-facing and read-pointer signals of the async FIFO
// write-side pointer generator.
//
// Handshake: wr_en_in is the producer's request; a write is accepted on a
// rising clk edge exactly when wr_accept_out is high at that edge
// (wr_accept_out = wr_en_in & ~full_out). A request that is not accepted is
// simply not taken; the producer keeps wr_en_in high to retry.
//
// Signals:
//   wr_en_in          producer write request
//   rptr_grey_sync_in read pointer (Gray), already synchronized to clk
//   waddr_out         memory write address
//   wptr_grey_out     registered Gray write pointer for the read domain
//   full_out          registered full flag
//   wr_accept_out     memory write strobe
//   almost_full_out   registered almost-full flag (WPTR_ALMOST_FULL_EN only)
//
// modport slave  : used by the pointer generator
// modport master : used by the producer / test environment
interface wptr_binary_to_grey_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en_in;
    logic [ADDR_WIDTH:0]   rptr_grey_sync_in;
    logic [ADDR_WIDTH-1:0] waddr_out;
    logic [ADDR_WIDTH:0]   wptr_grey_out;
    logic                  full_out;
    logic                  wr_accept_out;
`ifdef WPTR_ALMOST_FULL_EN
    logic                  almost_full_out;
`endif

    modport slave (
        input  wr_en_in,
        input  rptr_grey_sync_in,
        output waddr_out,
        output wptr_grey_out,
        output full_out,
`ifdef WPTR_ALMOST_FULL_EN
        output almost_full_out,
`endif
        output wr_accept_out
    );

    modport master (
        output wr_en_in,
        output rptr_grey_sync_in,
        input  waddr_out,
        input  wptr_grey_out,
        input  full_out,
`ifdef WPTR_ALMOST_FULL_EN
        input  almost_full_out,
`endif
        input  wr_accept_out
    );
endinterface

// File: rtl/wptr_binary_to_grey.sv
// wptr_binary_to_grey
// Write-side pointer generator for the asynchronous FIFO. Keeps the binary
// write pointer, registers its Gray encoding for crossing into the read
// domain, and produces a registered full flag by comparing the next Gray
// write pointer against the synchronized Gray read pointer.
//
// Ports:
//   clk    write-domain clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    wptr_binary_to_grey_if.slave (wr_en_in, rptr_grey_sync_in,
//          waddr_out, wptr_grey_out, full_out, wr_accept_out
//          [, almost_full_out])
//
// Optional feature: define WPTR_ALMOST_FULL_EN to add almost_full_out,
// asserted when at least DEPTH-1 entries are occupied.
module wptr_binary_to_grey #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wptr_binary_to_grey_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Inverting the two top bits of a Gray pointer gives the Gray value
    // exactly DEPTH positions ahead. For ADDR_WIDTH=1 this mask covers both
    // bits, which is the degenerate case of the same rule.
    localparam logic [PW-1:0] FULL_MASK = {PW{1'b1}} ^ ({PW{1'b1}} >> 2);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgrey;
    logic          full;
    logic          wr_accept;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgrey_next;
    logic          full_next;

    assign wr_accept  = bus.wr_en_in & ~full;
    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_accept};
    assign wgrey_next = (wbin_next >> 1) ^ wbin_next;
    // Uses the post-write pointer so full rises on the filling write itself.
    assign full_next  = (wgrey_next == (bus.rptr_grey_sync_in ^ FULL_MASK));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbin  <= '0;
            wgrey <= '0;
            full  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgrey <= wgrey_next;
            full  <= full_next;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - 1);

    logic [PW-1:0] rbin;
    logic [PW-1:0] occupancy_next;
    logic          almost_full;

    // Gray to binary: each binary bit is the XOR of all Gray bits above and
    // including it, accumulated from the MSB down.
    always_comb begin
        rbin = bus.rptr_grey_sync_in;
        for (int i = PW - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ bus.rptr_grey_sync_in[i];
        end
    end

    // Modulo subtraction across the wrap bit gives the occupancy directly;
    // a full FIFO reads DEPTH, so the flag stays set while full.
    assign occupancy_next = wbin_next - rbin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (occupancy_next >= AF_LEVEL);
        end
    end

    assign bus.almost_full_out = almost_full;
`endif

    assign bus.waddr_out     = wbin[ADDR_WIDTH-1:0];
    assign bus.wptr_grey_out = wgrey;
    assign bus.full_out      = full;
    assign bus.wr_accept_out = wr_accept;
endmodule

// File: tb/tb_wptr_binary_to_grey.sv
// tb_wptr_binary_to_grey
// Directed bench for the async FIFO write pointer generator. A count-based
// model (writes accepted vs. read position, as integers) predicts the
// outputs; a compare process checks them on every falling edge, and the
// directed sequences add literal expectations taken from hand-worked tables.
module tb_wptr_binary_to_grey;
    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 2 ** AW;
    localparam int MOD   = 2 * DEPTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wptr_binary_to_grey_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_binary_to_grey #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    function automatic logic [PW-1:0] gray_of(input int n);
        logic [PW-1:0] b;
        b = PW'(n % MOD);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // m_wcnt: accepted writes modulo 2*DEPTH. Occupancy is m_wcnt - rd_cnt.
    int   m_wcnt  = 0;
    logic m_full  = 1'b0;
    logic m_af    = 1'b0;
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        int nw;
        int occ;
        if (!rst_n) begin
            m_wcnt  <= 0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            nw  = (m_wcnt + ((bus.wr_en_in && !m_full) ? 1 : 0)) % MOD;
            occ = (nw - rd_cnt + MOD) % MOD;
            m_wcnt <= nw;
            m_full <= (occ == DEPTH);
            m_af   <= (occ >= DEPTH - 1);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("waddr", 32'(bus.waddr_out), 32'(m_wcnt % DEPTH));
            chk("wgrey", 32'(bus.wptr_grey_out), 32'(gray_of(m_wcnt)));
            chk("full", 32'(bus.full_out), 32'(m_full));
            chk("accept", 32'(bus.wr_accept_out), 32'(bus.wr_en_in & ~m_full));
`ifdef WPTR_ALMOST_FULL_EN
            chk("almost_full", 32'(bus.almost_full_out), 32'(m_af));
`endif
        end
    end

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the falling edge, so both the compare
    // process and the rising edge see them stable.
    task automatic cycle(input logic rst_v, input logic wr, input int rc);
        rst_n                 = rst_v;
        bus.wr_en_in          = wr;
        rd_cnt                = rc;
        bus.rptr_grey_sync_in = gray_of(rc);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [PW-1:0] exp_grey [8];
    logic [PW-1:0] prev_grey;

    initial begin
        exp_grey[0] = 4'b0001; exp_grey[1] = 4'b0011;
        exp_grey[2] = 4'b0010; exp_grey[3] = 4'b0110;
        exp_grey[4] = 4'b0111; exp_grey[5] = 4'b0101;
        exp_grey[6] = 4'b0100; exp_grey[7] = 4'b1100;

        @(negedge clk); #1;

        // Reset held two edges with a write pending: nothing advances.
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 0);
        chk("rst_waddr", 32'(bus.waddr_out), 32'd0);
        chk("rst_grey", 32'(bus.wptr_grey_out), 32'd0);
        chk("rst_full", 32'(bus.full_out), 32'd0);
        chk("rst_accept", 32'(bus.wr_accept_out), 32'd1);

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 0);
            chk("fill_grey", 32'(bus.wptr_grey_out), 32'(exp_grey[i]));
            chk("fill_waddr", 32'(bus.waddr_out), 32'((i + 1) % 8));
            chk("fill_full", 32'(bus.full_out), (i == 7) ? 32'd1 : 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
            chk("fill_af", 32'(bus.almost_full_out), (i >= 6) ? 32'd1 : 32'd0);
`endif
        end

        // Writes while full are refused and the pointer holds.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 0);
            chk("wfull_accept", 32'(bus.wr_accept_out), 32'd0);
            chk("wfull_grey", 32'(bus.wptr_grey_out), 32'h0c);
            chk("wfull_waddr", 32'(bus.waddr_out), 32'd0);
        end

        // Drain one entry, then refill.
        cycle(1'b1, 1'b0, 1);
        chk("drain_full", 32'(bus.full_out), 32'd0);
        cycle(1'b1, 1'b1, 1);
        chk("refill_grey", 32'(bus.wptr_grey_out), 32'h0d);
        chk("refill_full", 32'(bus.full_out), 32'd1);

        // Reset in the middle of a full FIFO with a write pending.
        cycle(1'b0, 1'b1, 1);
        chk("midrst_full", 32'(bus.full_out), 32'd0);
        chk("midrst_grey", 32'(bus.wptr_grey_out), 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
        chk("midrst_af", 32'(bus.almost_full_out), 32'd0);
`endif

        // Wrap: reader one write behind, pointer travels the full Gray cycle.
        cycle(1'b0, 1'b0, 0);
        prev_grey = bus.wptr_grey_out;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, i);
            chk("wrap_onebit", 32'($countones(bus.wptr_grey_out ^ prev_grey)), 32'd1);
            chk("wrap_full", 32'(bus.full_out), 32'd0);
            if (i == 14) chk("wrap_1000", 32'(bus.wptr_grey_out), 32'h08);
            if (i == 15) chk("wrap_0000", 32'(bus.wptr_grey_out), 32'h00);
            prev_grey = bus.wptr_grey_out;
        end
        chk("wrap_waddr", 32'(bus.waddr_out), 32'd0);

        cycle(1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
